// File: rtl/rs_error_corrector.sv
// RS(255,251) receive-side corrector: ping-pong buffers each codeword while the decoder runs,
// then streams the 251 data bytes with the located error values XORed in.
module rs_error_corrector #(
  parameter int unsigned NN = 255,
  parameter int unsigned KK = 251,
  parameter int unsigned TT = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din_val,
  input  logic       din_sop,
  input  logic       din_eop,
  input  logic [7:0] din,
  input  logic [7:0] el1,
  input  logic [7:0] el2,
  input  logic [7:0] ev1,
  input  logic [7:0] ev2,
  input  logic [1:0] error_num,
  input  logic       dec_done,
  input  logic       dec_fail,
  output logic       dout_val,
  output logic       dout_sop,
  output logic       dout_eop,
  output logic [7:0] dout,
  output logic       dout_fail,
  output logic [1:0] corr_cnt,
  output logic       in_busy,
  output logic       frame_err,
  output logic       orphan
);

  localparam logic [7:0] LastIn  = 8'(NN - 1);
  localparam logic [7:0] LastOut = 8'(KK - 1);
  localparam logic [7:0] KkByte  = 8'(KK);

  typedef enum logic [0:0] {StIdle, StOut} state_e;

  // Buffer storage: {bank, index}
  logic [7:0] r_mem [0:511];
  logic [7:0] r_rd_data;

  // Write side
  logic       r_wr_bank;
  logic [7:0] r_wr_cnt;
  logic       r_wr_act;
  logic [7:0] w_wr_cnt_nxt;
  logic       w_wr_act_nxt;
  logic       w_we;
  logic [7:0] w_widx;
  logic       w_frame_done;
  logic       w_ferr;
  logic       w_busy;

  // Per-bank status and decoder results
  logic [1:0]      r_full;
  logic [1:0]      r_res;
  logic [1:0]      r_fail;
  logic [1:0]      r_en1;
  logic [1:0]      r_en2;
  logic [1:0][7:0] r_el1;
  logic [1:0][7:0] r_el2;
  logic [1:0][7:0] r_ev1;
  logic [1:0][7:0] r_ev2;
  logic            r_frame_err;
  logic            r_orphan;
  logic            w_dec;
  logic            w_tgt_ok;
  logic            w_tgt_bank;

  // Read side
  state_e     r_state;
  state_e     w_state_nxt;
  logic [7:0] r_idx;
  logic [7:0] w_idx_nxt;
  logic       r_rd_bank;
  logic       w_bank_nxt;
  logic       w_oth_bank;
  logic       w_ready_cur;
  logic       w_ready_oth;
  logic       w_release;
  logic       w_start;
  logic [1:0] r_corr_cnt;
  logic [1:0] w_corr_nxt;
  logic       w_c1;
  logic       w_c2;
  logic       w_hit1;
  logic       w_hit2;

  assign w_busy = r_full[0] & r_full[1];

  always_comb begin
    w_wr_cnt_nxt = r_wr_cnt;
    w_wr_act_nxt = r_wr_act;
    w_we         = 1'b0;
    w_widx       = r_wr_cnt;
    w_frame_done = 1'b0;
    w_ferr       = 1'b0;
    if (din_val) begin
      if (w_busy) begin
        w_ferr = din_eop;
      end else if (din_sop) begin
        // A sop inside an open frame drops that frame and restarts on this byte
        w_ferr       = r_wr_act | din_eop;
        w_we         = 1'b1;
        w_widx       = 8'd0;
        w_wr_cnt_nxt = 8'd0;
        w_wr_act_nxt = ~din_eop;
      end else if (r_wr_act) begin
        if (r_wr_cnt == LastIn) begin
          w_ferr       = 1'b1;
          w_wr_act_nxt = 1'b0;
        end else begin
          w_we         = 1'b1;
          w_widx       = r_wr_cnt + 8'd1;
          w_wr_cnt_nxt = r_wr_cnt + 8'd1;
          if (din_eop) begin
            w_wr_act_nxt = 1'b0;
            if (r_wr_cnt + 8'd1 == LastIn) begin
              w_frame_done = 1'b1;
            end else begin
              w_ferr = 1'b1;
            end
          end
        end
      end else begin
        w_ferr = din_eop;
      end
    end
  end

  assign w_dec      = dec_done | dec_fail;
  assign w_oth_bank = ~r_rd_bank;

  // Banks fill and drain in order, so the read bank is always the oldest one
  always_comb begin
    w_tgt_ok   = 1'b0;
    w_tgt_bank = r_rd_bank;
    if (r_full[r_rd_bank] && !r_res[r_rd_bank]) begin
      w_tgt_ok = 1'b1;
    end else if (r_full[w_oth_bank] && !r_res[w_oth_bank]) begin
      w_tgt_ok   = 1'b1;
      w_tgt_bank = w_oth_bank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= 8'd0;
      r_wr_act    <= 1'b0;
      r_full      <= 2'b00;
      r_res       <= 2'b00;
      r_fail      <= 2'b00;
      r_en1       <= 2'b00;
      r_en2       <= 2'b00;
      r_el1       <= '0;
      r_el2       <= '0;
      r_ev1       <= '0;
      r_ev2       <= '0;
      r_frame_err <= 1'b0;
      r_orphan    <= 1'b0;
    end else begin
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_wr_act    <= w_wr_act_nxt;
      r_frame_err <= w_ferr;
      r_orphan    <= w_dec & ~w_tgt_ok;
      if (w_frame_done) begin
        r_full[r_wr_bank] <= 1'b1;
        r_wr_bank         <= ~r_wr_bank;
      end
      if (w_release) begin
        r_full[r_rd_bank] <= 1'b0;
        r_res[r_rd_bank]  <= 1'b0;
      end
      if (w_dec && w_tgt_ok) begin
        r_res[w_tgt_bank]  <= 1'b1;
        r_fail[w_tgt_bank] <= dec_fail;
        r_en1[w_tgt_bank]  <= !dec_fail && (error_num >= 2'd1);
        r_en2[w_tgt_bank]  <= !dec_fail && (TT >= 2) && (error_num >= 2'd2);
        r_el1[w_tgt_bank]  <= el1;
        r_el2[w_tgt_bank]  <= el2;
        r_ev1[w_tgt_bank]  <= ev1;
        r_ev2[w_tgt_bank]  <= ev2;
      end
    end
  end

  assign w_ready_cur = r_full[r_rd_bank] & r_res[r_rd_bank];
  assign w_ready_oth = r_full[w_oth_bank] & r_res[w_oth_bank];

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_bank_nxt  = r_rd_bank;
    w_release   = 1'b0;
    w_start     = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_ready_cur) begin
          w_state_nxt = StOut;
          w_idx_nxt   = 8'd0;
          w_start     = 1'b1;
        end
      end
      StOut: begin
        if (r_idx == LastOut) begin
          w_release  = 1'b1;
          w_bank_nxt = w_oth_bank;
          w_idx_nxt  = 8'd0;
          if (w_ready_oth) begin
            w_state_nxt = StOut;
            w_start     = 1'b1;
          end else begin
            w_state_nxt = StIdle;
          end
        end else begin
          w_idx_nxt = r_idx + 8'd1;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  assign w_c1       = r_en1[w_bank_nxt] && (r_el1[w_bank_nxt] < KkByte);
  assign w_c2       = r_en2[w_bank_nxt] && (r_el2[w_bank_nxt] < KkByte);
  assign w_corr_nxt = {1'b0, w_c1} + {1'b0, w_c2};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StIdle;
      r_idx      <= 8'd0;
      r_rd_bank  <= 1'b0;
      r_corr_cnt <= 2'd0;
    end else begin
      r_state   <= w_state_nxt;
      r_idx     <= w_idx_nxt;
      r_rd_bank <= w_bank_nxt;
      if (w_start) begin
        r_corr_cnt <= w_corr_nxt;
      end
    end
  end

  // Read address uses next-state so data lines up with the first output cycle
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[{r_wr_bank, w_widx}] <= din;
    end
    r_rd_data <= r_mem[{w_bank_nxt, w_idx_nxt}];
  end

  assign w_hit1 = r_en1[r_rd_bank] && (r_el1[r_rd_bank] == r_idx);
  assign w_hit2 = r_en2[r_rd_bank] && (r_el2[r_rd_bank] == r_idx);

  assign dout_val  = (r_state == StOut);
  assign dout_sop  = dout_val && (r_idx == 8'd0);
  assign dout_eop  = dout_val && (r_idx == LastOut);
  assign dout_fail = dout_val && r_fail[r_rd_bank];
  assign dout      = dout_val ? (r_rd_data ^ (w_hit1 ? r_ev1[r_rd_bank] : 8'd0)
                                           ^ (w_hit2 ? r_ev2[r_rd_bank] : 8'd0)) : 8'd0;
  assign corr_cnt  = r_corr_cnt;
  assign in_busy   = w_busy;
  assign frame_err = r_frame_err;
  assign orphan    = r_orphan;

endmodule

// File: tb/tb_rs_error_corrector.sv
// Bench for rs_error_corrector: acts as upstream source and decoder, checks output against
// a frame-level model of the correction rules.
module tb_rs_error_corrector;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       din_val = 1'b0, din_sop = 1'b0, din_eop = 1'b0;
  logic [7:0] din = 8'd0;
  logic [7:0] el1 = 8'd0, el2 = 8'd0, ev1 = 8'd0, ev2 = 8'd0;
  logic [1:0] error_num = 2'd0;
  logic       dec_done = 1'b0, dec_fail = 1'b0;
  logic       dout_val, dout_sop, dout_eop, dout_fail, in_busy, frame_err, orphan;
  logic [7:0] dout;
  logic [1:0] corr_cnt;

  rs_error_corrector dut (
    .clk(clk), .rst(rst), .din_val(din_val), .din_sop(din_sop), .din_eop(din_eop),
    .din(din), .el1(el1), .el2(el2), .ev1(ev1), .ev2(ev2), .error_num(error_num),
    .dec_done(dec_done), .dec_fail(dec_fail), .dout_val(dout_val), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .dout(dout), .dout_fail(dout_fail), .corr_cnt(corr_cnt),
    .in_busy(in_busy), .frame_err(frame_err), .orphan(orphan)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       sop;
    logic       eop;
    logic       fail;
    logic [1:0] cnt;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] fb [255];
  int n_vec = 0, n_err = 0;
  int cyc = 0, dec_cyc = 0, last_sop_cyc = 0;
  int tot_out = 0, run = 0, max_run = 0;
  int ferr_cnt = 0, orph_cnt = 0, exp_ferr = 0, exp_orph = 0;
  logic busy_seen = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    if (dout_val) begin
      if (exp_q.size() == 0) begin
        check("unexpected_dout_val", 32'(dout_val), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dout", 32'(dout), 32'(e.d));
        check("dout_sop", 32'(dout_sop), 32'(e.sop));
        check("dout_eop", 32'(dout_eop), 32'(e.eop));
        check("dout_fail", 32'(dout_fail), 32'(e.fail));
        if (e.sop) begin
          check("corr_cnt", 32'(corr_cnt), 32'(e.cnt));
          last_sop_cyc = cyc;
        end
      end
      run++;
      tot_out++;
    end else begin
      run = 0;
    end
    if (run > max_run) max_run = run;
    if (in_busy) busy_seen = 1'b1;
    if (frame_err) ferr_cnt++;
    if (orphan) orph_cnt++;
  end

  task automatic send_frame(input int len);
    for (int i = 0; i < len; i++) begin
      din_val = 1'b1;
      din_sop = (i == 0);
      din_eop = (i == len - 1);
      din     = fb[i];
      step();
    end
    din_val = 1'b0;
    din_sop = 1'b0;
    din_eop = 1'b0;
    if (len == 255) begin
      for (int i = 0; i < 255; i++) pend_q.push_back(fb[i]);
    end else begin
      exp_ferr++;
    end
  endtask

  // Decoder result pulse; the model turns the oldest pending frame into expected output.
  task automatic dec_pulse(input logic done, input logic fail, input logic [1:0] n,
                           input logic [7:0] l1, input logic [7:0] v1,
                           input logic [7:0] l2, input logic [7:0] v2);
    logic [7:0] raw [255];
    exp_t e;
    int c;
    if (pend_q.size() < 255) begin
      exp_orph++;
    end else begin
      for (int i = 0; i < 255; i++) raw[i] = pend_q.pop_front();
      c = 0;
      if (!fail && n >= 1 && l1 < 251) c++;
      if (!fail && n >= 2 && l2 < 251) c++;
      for (int i = 0; i < 251; i++) begin
        e.d = raw[i];
        if (!fail && n >= 1 && int'(l1) == i) e.d = e.d ^ v1;
        if (!fail && n >= 2 && int'(l2) == i) e.d = e.d ^ v2;
        e.sop  = (i == 0);
        e.eop  = (i == 250);
        e.fail = fail;
        e.cnt  = 2'(c);
        exp_q.push_back(e);
      end
    end
    dec_done = done; dec_fail = fail; error_num = n;
    el1 = l1; ev1 = v1; el2 = l2; ev2 = v2;
    dec_cyc = cyc;
    step();
    dec_done = 1'b0; dec_fail = 1'b0; error_num = 2'd0;
  endtask

  task automatic drain(input logic chk_lat);
    int g = 0;
    while ((exp_q.size() != 0 || dout_val) && g < 3000) begin
      step();
      g++;
    end
    check("drain_left", 32'(exp_q.size()), 32'd0);
    if (chk_lat) check("latency", 32'(last_sop_cyc - dec_cyc), 32'd2);
  endtask

  task automatic wait_not_busy();
    int g = 0;
    while (in_busy && g < 2000) begin
      step();
      g++;
    end
    check("busy_timeout", 32'(in_busy), 32'd0);
  endtask

  task automatic clean_fb();
    for (int i = 0; i < 251; i++) fb[i] = 8'(251 - i);
    for (int i = 251; i < 255; i++) fb[i] = 8'(8'hA0 + i - 251);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_dout_val"}, 32'(dout_val), 32'd0);
    check({tag, "_dout"}, 32'(dout), 32'd0);
    check({tag, "_sop_eop_fail"}, {29'd0, dout_sop, dout_eop, dout_fail}, 32'd0);
    check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'd0);
    check({tag, "_flags"}, {29'd0, in_busy, frame_err, orphan}, 32'd0);
  endtask

  initial begin
    int tgt, g;
    logic [7:0] l1r, l2r;
    int kind;

    repeat (3) step();
    check_quiet("reset");
    rst = 1'b0;
    step();

    // Clean frame
    clean_fb();
    send_frame(255);
    repeat (5) step();
    dec_pulse(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    drain(1'b1);

    // Two corrupted bytes repaired
    clean_fb();
    fb[10] = 8'h0A;
    fb[30] = 8'h00;
    send_frame(255);
    dec_pulse(1'b1, 1'b0, 2'd2, 8'd10, 8'(251 - 10) ^ 8'h0A, 8'd30, 8'(251 - 30));
    drain(1'b1);

    // Uncorrectable frame
    for (int i = 0; i < 255; i++) fb[i] = 8'($urandom);
    send_frame(255);
    repeat (3) step();
    dec_pulse(1'b0, 1'b1, 2'd2, 8'd5, 8'h11, 8'd6, 8'h22);
    drain(1'b1);

    // Back-to-back frames, second result arrives during first output
    max_run = 0;
    busy_seen = 1'b0;
    clean_fb();
    send_frame(255);
    for (int i = 0; i < 255; i++) fb[i] = 8'($urandom);
    send_frame(255);
    dec_pulse(1'b1, 1'b0, 2'd1, 8'd250, 8'h5A, 8'd0, 8'd0);
    repeat (100) step();
    dec_pulse(1'b1, 1'b0, 2'd2, 8'd0, 8'hFF, 8'd252, 8'h33);
    drain(1'b0);
    check("b2b_run", 32'(max_run), 32'd502);
    check("b2b_busy", 32'(busy_seen), 32'd1);

    // Short frame dropped, then an orphan result
    clean_fb();
    send_frame(201);
    repeat (3) step();
    check("frame_err_cnt", 32'(ferr_cnt), 32'(exp_ferr));
    dec_pulse(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    repeat (3) step();
    check("orphan_cnt", 32'(orph_cnt), 32'(exp_orph));
    check("no_output", 32'(exp_q.size()), 32'd0);

    // Reset while streaming, then recover
    clean_fb();
    send_frame(255);
    dec_pulse(1'b1, 1'b0, 2'd1, 8'd7, 8'h01, 8'd0, 8'd0);
    tgt = tot_out + 100;
    g = 0;
    while (tot_out < tgt && g < 1000) begin
      step();
      g++;
    end
    check("rst_reached", 32'(tot_out >= tgt), 32'd1);
    rst = 1'b1;
    step();
    check_quiet("midrst");
    exp_q.delete();
    pend_q.delete();
    rst = 1'b0;
    step();
    clean_fb();
    send_frame(255);
    dec_pulse(1'b1, 1'b0, 2'd0, 8'd0, 8'd0, 8'd0, 8'd0);
    drain(1'b1);

    // Randomised frames and decoder results
    for (int f = 0; f < 10; f++) begin
      for (int i = 0; i < 255; i++) fb[i] = 8'($urandom);
      wait_not_busy();
      send_frame(255);
      repeat ($urandom_range(0, 15)) step();
      kind = $urandom_range(0, 9);
      l1r = 8'($urandom_range(0, 255));
      l2r = 8'($urandom_range(0, 255));
      if (l2r == l1r) l2r = l1r + 8'd1;
      if (kind == 0) dec_pulse(1'b0, 1'b1, 2'd0, l1r, 8'($urandom), l2r, 8'($urandom));
      else if (kind == 1) dec_pulse(1'b1, 1'b1, 2'd2, l1r, 8'($urandom), l2r, 8'($urandom));
      else dec_pulse(1'b1, 1'b0, 2'($urandom_range(0, 2)), l1r, 8'($urandom), l2r,
                     8'($urandom));
    end
    drain(1'b0);
    check("final_frame_err", 32'(ferr_cnt), 32'(exp_ferr));
    check("final_orphan", 32'(orph_cnt), 32'(exp_orph));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
